// File: rtl/jkchk_pkg.sv
// Shared types for the JK flip-flop checker: FSM states, JK mode codes and the
// JK next-state function used by the reference model.
package jkchk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic nxt;
    case ({j, k})
      HOLD:    nxt = q;
      RESET:   nxt = 1'b0;
      SET:     nxt = 1'b1;
      default: nxt = ~q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_checker_if.sv
// Observation bus between a JK flip-flop under test and its checker.
// Coverage outputs exist only when JKCHK_COVERAGE_EN is defined.
interface jk_ff_checker_if #(parameter int CNT_W = 16);

  logic             en;
  logic             clr;
  logic             j;
  logic             k;
  logic             q;
  logic             q_bar;
  logic             exp_q;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       state;
`ifdef JKCHK_COVERAGE_EN
  logic [CNT_W-1:0] cov_hold;
  logic [CNT_W-1:0] cov_reset;
  logic [CNT_W-1:0] cov_set;
  logic [CNT_W-1:0] cov_toggle;
  logic             cov_done;
`endif

  modport master (
    output en, clr, j, k, q, q_bar,
    input  exp_q, err_pulse, err_sticky, chk_count, err_count, state
`ifdef JKCHK_COVERAGE_EN
    , input cov_hold, cov_reset, cov_set, cov_toggle, cov_done
`endif
  );

  modport slave (
    input  en, clr, j, k, q, q_bar,
    output exp_q, err_pulse, err_sticky, chk_count, err_count, state
`ifdef JKCHK_COVERAGE_EN
    , output cov_hold, cov_reset, cov_set, cov_toggle, cov_done
`endif
  );

endinterface

// File: rtl/jkchk_sat_counter.sv
// Saturating up-counter: clr wins, freeze holds, stops at all-ones.
// Latency: count reflects inc one edge later; no backpressure.
module jkchk_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !freeze && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/jk_ff_checker.sv
// JK flip-flop observer: cycle-accurate reference model, mismatch flags and counters.
// Optional JKCHK_COVERAGE_EN adds per-mode coverage counters; results one edge after sampling.
// Pure observer: no backpressure, inputs are sampled every rising edge.
module jk_ff_checker #(
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input logic             clk,
  input logic             rst_n,
  jk_ff_checker_if.slave  bus
);

  import jkchk_pkg::*;

  state_t st;
  logic   j_r, k_r, q_r;
  logic   exp_q_r, err_pulse_r, err_sticky_r;
  logic   cmp, exp_now, mismatch, halted;

  // A compare happens only on an enabled CHECK edge that is not being cleared.
  assign cmp      = (st == CHECK) && bus.en && !bus.clr;
  assign exp_now  = jk_next(j_r, k_r, q_r);
  assign mismatch = (bus.q != exp_now) || (bus.q_bar != ~bus.q);
  assign halted   = (st == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      j_r          <= 1'b0;
      k_r          <= 1'b0;
      q_r          <= 1'b0;
      exp_q_r      <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
    end else if (bus.clr) begin
      st           <= IDLE;
      exp_q_r      <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          exp_q_r     <= 1'b0;
          err_pulse_r <= 1'b0;
          if (bus.en) st <= ARM;
        end
        ARM: begin
          exp_q_r     <= 1'b0;
          err_pulse_r <= 1'b0;
          if (!bus.en) begin
            st <= IDLE;
          end else begin
            j_r <= bus.j;
            k_r <= bus.k;
            q_r <= bus.q;
            st  <= CHECK;
          end
        end
        CHECK: begin
          if (!bus.en) begin
            st          <= IDLE;
            exp_q_r     <= 1'b0;
            err_pulse_r <= 1'b0;
          end else begin
            exp_q_r     <= exp_now;
            err_pulse_r <= mismatch;
            if (mismatch) err_sticky_r <= 1'b1;
            // Resync on the observed q so a single fault does not cascade.
            j_r <= bus.j;
            k_r <= bus.k;
            q_r <= bus.q;
            if (mismatch && (STOP_ON_ERR != 0)) st <= HALT;
          end
        end
        HALT: begin
          err_pulse_r <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.exp_q      = exp_q_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.err_sticky = err_sticky_r;

  logic [CNT_W-1:0] chk_cnt, err_cnt;

  jkchk_sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk(clk), .rst_n(rst_n), .inc(cmp), .clr(bus.clr), .freeze(halted), .count(chk_cnt)
  );

  jkchk_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .inc(cmp && mismatch), .clr(bus.clr), .freeze(halted),
    .count(err_cnt)
  );

  assign bus.chk_count = chk_cnt;
  assign bus.err_count = err_cnt;

`ifdef JKCHK_COVERAGE_EN
  logic [1:0]       mode;
  logic [CNT_W-1:0] cov_h, cov_r, cov_s, cov_t;

  assign mode = {j_r, k_r};

  jkchk_sat_counter #(.W(CNT_W)) u_cov_hold (
    .clk(clk), .rst_n(rst_n), .inc(cmp && (mode == HOLD)), .clr(bus.clr), .freeze(halted),
    .count(cov_h)
  );
  jkchk_sat_counter #(.W(CNT_W)) u_cov_reset (
    .clk(clk), .rst_n(rst_n), .inc(cmp && (mode == RESET)), .clr(bus.clr), .freeze(halted),
    .count(cov_r)
  );
  jkchk_sat_counter #(.W(CNT_W)) u_cov_set (
    .clk(clk), .rst_n(rst_n), .inc(cmp && (mode == SET)), .clr(bus.clr), .freeze(halted),
    .count(cov_s)
  );
  jkchk_sat_counter #(.W(CNT_W)) u_cov_toggle (
    .clk(clk), .rst_n(rst_n), .inc(cmp && (mode == TOGGLE)), .clr(bus.clr), .freeze(halted),
    .count(cov_t)
  );

  assign bus.cov_hold   = cov_h;
  assign bus.cov_reset  = cov_r;
  assign bus.cov_set    = cov_s;
  assign bus.cov_toggle = cov_t;
  assign bus.cov_done   = (cov_h != '0) && (cov_r != '0) && (cov_s != '0) && (cov_t != '0);
`endif

endmodule

// File: doc/jk_ff_checker.md
Name: jk_ff_checker

Overview:
- Hardware observer for a JK flip-flop: receives the J/K stimulus a JK flip-flop sees, plus its Q/Q_bar outputs.
- Maintains a cycle-accurate JK reference model, flags mismatches and counts checked and failed cycles.
- Sits beside any JK-style flip-flop in the flip-flop conversion library, both in the benches and on-chip as a self-test monitor.

Parameters:
- CNT_W, 16: width of the saturating counters chk_count and err_count.
- STOP_ON_ERR, 0: when 1, the first error moves the FSM to HALT and freezes all counters.

Ports:
- clk  input  1: single clock; all logic on its rising edge.
- rst_n  input  1: asynchronous active-low reset.
- en  input  1: checking enable; low holds the FSM in IDLE.
- clr  input  1: synchronous clear of counters, sticky flag and FSM (to IDLE). Takes priority over en.
- j  input  1: observed J, sampled on the same edge the observed flip-flop samples it.
- k  input  1: observed K.
- q  input  1: observed Q.
- q_bar  input  1: observed Q_bar.
- exp_q  output  1: model's expected Q for the current cycle.
- err_pulse  output  1: one-cycle pulse per mismatching cycle.
- err_sticky  output  1: set on the first error; cleared only by rst_n or clr.
- chk_count  output  CNT_W: number of compared cycles, saturating.
- err_count  output  CNT_W: number of erroneous cycles, saturating.
- state  output  2: FSM state encoding.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; exp_q=0; err_pulse=0; err_sticky=0; chk_count=0; err_count=0; internal j_r/k_r/q_r=0.
- State encoding: IDLE=0, ARM=1, CHECK=2, HALT=3.
- IDLE: no compares. Transitions to ARM on a clock edge where en=1 and clr=0.
- ARM: captures j, k, q into j_r/k_r/q_r. No compare. Moves to CHECK on the next edge.
- CHECK, every edge with en=1:
  - Compute exp = jk_next(j_r, k_r, q_r): 00 gives q_r (hold), 01 gives 0, 10 gives 1, 11 gives ~q_r.
  - Error when q != exp, or when q_bar != ~q.
  - chk_count increments by 1; on error, err_count increments by 1, err_pulse=1 for one cycle, err_sticky=1.
  - Re-capture j, k and the observed q (not exp) into j_r/k_r/q_r. Resynchronising on the observed q keeps one fault from causing a cascade of errors.
- exp_q is registered: it holds the exp used in the most recent compare; 0 outside CHECK.
- en deasserted in CHECK or ARM: return to IDLE on that edge. Counters and err_sticky are retained. Re-enabling re-arms with no compare on the first cycle.
- STOP_ON_ERR=1: an erroneous compare moves CHECK to HALT. HALT ignores en; all outputs are frozen except err_pulse, which falls to 0. Only clr or rst_n leave HALT.
- Saturation: counters stop at 2^CNT_W-1. A compare at saturation still raises err_pulse.
- clr and en both high: clr wins and the state is IDLE after the edge. ARM is entered on the following edge.
- rst_n asserted mid-CHECK: every register returns to its reset value immediately, with no clock required.

Optional Feature:
- Macro JKCHK_COVERAGE_EN.
- Defined:
  - Adds outputs cov_hold, cov_reset, cov_set and cov_toggle, each CNT_W wide and saturating. Each increments on a CHECK compare whose j_r/k_r is 00, 01, 10 or 11 respectively.
  - Adds a cov_done output (1 bit) that is high once all four counters are non-zero.
  - All of these clear on rst_n or clr and freeze in HALT.
- Undefined: the ports and their logic are absent, and the rest of the behaviour is unchanged.

Decomposition:
- Shared package jkchk_pkg holds:
  - the state enum (IDLE/ARM/CHECK/HALT);
  - the JK mode constants HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11;
  - the function jk_next(j, k, q).
- One sub-module, jkchk_sat_counter, parameterised by width, with inputs inc, clr and freeze. It is instantiated for chk_count, err_count and the coverage counters.

Test Plan:
1. Reset, then en=1 with a correct JK model driving q/q_bar. Sequence JK=00,10,00,01,11,11 -> ARM for 1 cycle, then 5 compares; chk_count=5, err_count=0, err_sticky=0, exp_q trace 0,1,1,0,1.
2. Correct model with q forced to 0 for one cycle after JK=10 -> exactly one err_pulse, err_count=1, err_sticky=1. The next cycle is compared against the observed q and does not error.
3. Drive q_bar=q for one cycle with q correct -> err_pulse=1, err_count=1.
4. STOP_ON_ERR=1, inject an error, then drop en -> state=3 (HALT) remains; counters frozen at the error values; clr returns state to 0 and all counters to 0.
5. CNT_W=3 with 10 good compares -> chk_count stays at 7. An injected error raises err_pulse=1 and err_count=1.
6. rst_n pulsed low between clock edges in CHECK -> outputs reach their reset values before the next edge. With JKCHK_COVERAGE_EN, all four JK modes exercised -> cov_done=1 and each cov_* >= 1.
